ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_line_sync.sv | 48 ++++
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types, command constants and the parity helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQUEST = 3'd2,
        DATA    = 3'd3,
        PARITY  = 3'd4,
        STOP    = 3'd5,
        ACK     = 3'd6,
        RELEASE = 3'd7
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data_byte);
        return ~^data_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchronizer for PS2_CLK/PS2_DAT plus clock fall flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fall
);

    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        meta_d     = {i_ps2_dat, i_ps2_clk};
        sync_d     = meta_q;
        clk_prev_d = sync_q[0];
    end

    // Idle bus is high, so resetting to 1 avoids a false fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign o_clk_sync = sync_q[0];
    assign o_dat_sync = sync_q[1];
    assign o_clk_fall = clk_prev_q & ~sync_q[0];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter with ACK detection.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] command,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    import ps2_pkg::*;

    localparam int CNT_MAX_VAL = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_clk_fall;

    ps2_line_sync u_line_sync (
        .clk        (CLOCK_50),
        .rst        (reset),
        .i_ps2_clk  (ps2_clk_in),
        .i_ps2_dat  (ps2_dat_in),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_clk_fall)
    );

    ps2_tx_state_t    state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timed;

    always_comb begin
        w_cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        w_timed   = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP) ||
                    (state_q == ACK)  || (state_q == RELEASE);

        state_d  = state_q;
        cmd_d    = cmd_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (w_timed) begin
            cnt_d = w_cnt_inc;
        end

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (send) begin
                    cmd_d    = command;
                    parity_d = odd_parity(command);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = w_cnt_inc;
                if (cnt_q == INHIBIT_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = REQUEST;
                end
            end
            REQUEST: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                idx_d    = 3'd0;
                state_d  = DATA;
            end
            DATA: begin
                if (w_clk_fall) begin
                    dat_oe_d = ~cmd_q[idx_q];
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_clk_fall) begin
                    dat_oe_d = ~parity_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (w_clk_fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    if (!w_dat_sync) begin
                        state_d = RELEASE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (w_clk_sync && w_dat_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout overrides whatever the bus did in the same cycle.
        if (w_timed && (cnt_q == TIMEOUT_LAST)) begin
            done_d  = 1'b0;
            error_d = 1'b1;
            state_d = IDLE;
        end

        if (state_d == IDLE) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= 8'h00;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Bench for ps2_host_tx with an open-drain PS/2 device model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_host_tx;

    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int HP  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] command = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe, ready, busy, done, error;
    logic       pad_clk, pad_dat;

    assign pad_clk = ~(ps2_clk_oe | dev_clk_low);
    assign pad_dat = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .ps2_clk_in (pad_clk),
        .ps2_dat_in (pad_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .command    (command),
        .send       (send),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic end_busy  = 1'b0;
    logic end_ready = 1'b0;
    logic [9:0] dev_bits;

    // Pulse monitor: busy/ready read here were set on the same edge as the pulse.
    always @(posedge clk) begin
        if (done)          done_cnt <= done_cnt + 1;
        if (error)         err_cnt  <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
        if (done || error) begin
            end_busy  <= busy;
            end_ready <= ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_request(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pad_clk && !pad_dat && !ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("request_seen", 32'(ok), 1);
    endtask

    // One device clock pulse; the device reads data on the rising edge.
    task automatic dev_clock(input int k);
        cycles(HP);
        dev_clk_low = 1'b1;
        cycles(HP);
        dev_clk_low = 1'b0;
        if (k < 10) dev_bits[k] = pad_dat;
    endtask

    task automatic device_frame(input bit do_ack);
        bit ok;
        wait_request(ok);
        if (!ok) return;
        for (int k = 0; k < 10; k++) dev_clock(k);
        cycles(HP / 2);
        dev_dat_low = do_ack;
        cycles(HP / 2);
        dev_clk_low = 1'b1;
        cycles(HP);
        dev_clk_low = 1'b0;
        cycles(4);
        dev_dat_low = 1'b0;
    endtask

    task automatic run_tx(input logic [7:0] cmd, input bit do_ack, input bit extra_send);
        int   d0, e0, n, dat_first;
        bit   seen;
        logic exp_par;
        exp_par   = ($countones(cmd) % 2 == 0);
        dev_bits  = 10'h000;
        d0        = done_cnt;
        e0        = err_cnt;
        @(negedge clk);
        command = cmd;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        command = 8'($urandom);
        check("accept_clk_oe", 32'(ps2_clk_oe), 1);
        check("accept_ready", 32'(ready), 0);
        check("accept_busy", 32'(busy), 1);
        n = 0;
        dat_first = 0;
        while (ps2_clk_oe && n < INH + 50) begin
            n++;
            if (ps2_dat_oe && dat_first == 0) dat_first = n;
            if (extra_send && n == 5) begin
                command = 8'hF4;
                send    = 1'b1;
            end else if (n == 6) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'(INH + 1));
        check("start_lead", 32'(dat_first), 32'(INH + 1));
        device_frame(do_ack);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("end_seen", 32'(seen), 1);
        cycles(5);
        check("rx_byte", 32'(dev_bits[7:0]), 32'(cmd));
        check("rx_parity", 32'(dev_bits[8]), 32'(exp_par));
        check("rx_stop", 32'(dev_bits[9]), 1);
        check("done_count", 32'(done_cnt - d0), do_ack ? 1 : 0);
        check("error_count", 32'(err_cnt - e0), do_ack ? 0 : 1);
        check("end_busy", 32'(end_busy), 0);
        check("end_ready", 32'(end_ready), 1);
        check("idle_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    endtask

    initial begin
        int  d0, e0, n;
        bit  ok;

        cycles(3);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 0);
        check("rst_ready", 32'(ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({done, error}), 0);
        reset = 1'b0;
        cycles(2);

        run_tx(CMD_SET_LEDS, 1'b1, 1'b0);
        run_tx(8'h00, 1'b1, 1'b0);
        run_tx(CMD_RESET, 1'b1, 1'b0);
        run_tx(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) run_tx(8'($urandom), 1'b1, 1'b0);

        // Second send while busy must not disturb the first command.
        run_tx(8'h3C, 1'b1, 1'b1);

        // Device never pulls data low for ACK.
        run_tx(8'($urandom), 1'b0, 1'b0);

        // Device never clocks: timeout.
        @(negedge clk);
        command = 8'hA5;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n = 1;
        while (!error && n < INH + TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_window", 32'((n >= INH + TMO) && (n <= INH + TMO + 3)), 1);
        check("timeout_error", 32'(error), 1);
        check("timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        check("timeout_ready", 32'(ready), 1);
        cycles(3);

        // Reset in the middle of the data bits.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        command = 8'($urandom);
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_request(ok);
        for (int k = 0; k < 5; k++) dev_clock(k);
        cycles(HP / 2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        check("mid_rst_ready", 32'(ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        cycles(1);
        reset = 1'b0;
        cycles(10);
        check("mid_rst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        run_tx(CMD_RESET, 1'b1, 1'b0);

        check("never_both", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
